// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the store commit buffer: entry layout and drain FSM states.
package store_commit_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } sb_state_t;

endpackage

// File: rtl/store_commit_buffer_if.sv
// Store-commit, data-cache write and load-probe signals of the store commit buffer.
interface store_commit_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  st_stall;
  logic                  dc_req_valid;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic [DATA_WIDTH-1:0] dc_req_data;
  logic                  dc_req_ready;
  logic                  dc_wr_done;
  logic                  sb_empty;
  logic                  ld_lookup_valid;
  logic [ADDR_WIDTH-1:0] ld_lookup_addr;
  logic                  ld_fwd_hit;
  logic [DATA_WIDTH-1:0] ld_fwd_data;

  modport slave (
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    output st_stall,
    output dc_req_valid, dc_req_addr, dc_req_data,
    input  dc_req_ready, dc_wr_done,
    output sb_empty,
    input  ld_lookup_valid, ld_lookup_addr,
    output ld_fwd_hit, ld_fwd_data
  );

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    input  st_stall,
    input  dc_req_valid, dc_req_addr, dc_req_data,
    output dc_req_ready, dc_wr_done,
    input  sb_empty,
    output ld_lookup_valid, ld_lookup_addr,
    input  ld_fwd_hit, ld_fwd_data
  );

endinterface

// File: rtl/store_buf_fwd_match.sv
// Youngest-match search over the store buffer for load forwarding (STORE_BUF_FWD_EN builds only).
module store_buf_fwd_match
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  sb_entry_t            entries [SB_DEPTH],
  input  logic [$clog2(SB_DEPTH)-1:0] wr_idx,
  input  logic                 lookup_valid,
  input  logic [SB_ADDR_W-1:0] lookup_addr,
  output logic                 hit,
  output logic [SB_DATA_W-1:0] data
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from oldest slot (wr_idx) to youngest (wr_idx-1); the last match is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      idx = wr_idx + PTR_W'(k);
      if (lookup_valid && entries[idx].valid && (entries[idx].addr == lookup_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: FIFO of committed stores drained one at a time to the data cache.
// Optional load forwarding is built when STORE_BUF_FWD_EN is defined.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH   = 4,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_W,
  parameter int unsigned DATA_WIDTH = SB_DATA_W
) (
  input logic                  clk,
  input logic                  rst_n,
  store_commit_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] PtrOne = (PTR_W+1)'(1);

  if ((ADDR_WIDTH != SB_ADDR_W) || (DATA_WIDTH != SB_DATA_W)) begin : g_width_chk
    $error("store_commit_buffer: widths must match the package entry layout");
  end
  if ((SB_DEPTH < 2) || ((SB_DEPTH & (SB_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("store_commit_buffer: SB_DEPTH must be a power of 2 and at least 2");
  end

  sb_entry_t        entries_q [SB_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  sb_state_t        state_q;
  logic             req_valid_q;

  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             full, empty, push, pop;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign push   = bus.mem_wr_en && !full;
  // Completion only counts once the request was accepted; done in REQ is ignored.
  assign pop    = (state_q == StWait) && bus.dc_wr_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      req_valid_q <= 1'b0;
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      if (push) begin
        entries_q[wr_idx] <= '{valid: 1'b1, addr: bus.mem_wr_addr, data: bus.mem_wr_data};
        wr_ptr_q          <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        entries_q[rd_idx].valid <= 1'b0;
        rd_ptr_q                <= rd_ptr_q + PtrOne;
      end
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
          end
        end
        StReq: begin
          if (bus.dc_req_ready) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (bus.dc_wr_done) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.st_stall     = full;
  assign bus.sb_empty     = empty;
  assign bus.dc_req_valid = req_valid_q;
  assign bus.dc_req_addr  = entries_q[rd_idx].addr;
  assign bus.dc_req_data  = entries_q[rd_idx].data;

`ifdef STORE_BUF_FWD_EN
  store_buf_fwd_match #(
    .SB_DEPTH(SB_DEPTH)
  ) u_fwd_match (
    .entries     (entries_q),
    .wr_idx      (wr_idx),
    .lookup_valid(bus.ld_lookup_valid),
    .lookup_addr (bus.ld_lookup_addr),
    .hit         (bus.ld_fwd_hit),
    .data        (bus.ld_fwd_data)
  );
`else
  logic unused_lookup;

  always_comb begin
    unused_lookup = ^{bus.ld_lookup_valid, bus.ld_lookup_addr};
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      unused_lookup = unused_lookup ^ entries_q[i].valid;
    end
  end

  assign bus.ld_fwd_hit  = 1'b0;
  assign bus.ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Scoreboard bench for store_commit_buffer with a small data-cache responder model.
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  localparam int unsigned Depth = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_commit_buffer_if #(.ADDR_WIDTH(SB_ADDR_W), .DATA_WIDTH(SB_DATA_W)) bus ();

  store_commit_buffer #(
    .SB_DEPTH  (Depth),
    .ADDR_WIDTH(SB_ADDR_W),
    .DATA_WIDTH(SB_DATA_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of {addr,data} in commit order.
  logic [63:0] exp_q[$];
  int          n_push = 0;

  // Data-cache responder knobs.
  int ready_lat       = 0;
  int done_delay      = 1;
  bit done_with_ready = 1'b0;
  bit stray_done      = 1'b0;

  // Responder: acts 2 time units after each rising edge.
  initial begin
    int  wait_cnt;
    int  low_cnt;
    bit  prev_valid;
    bit  acc;
    wait_cnt = -1;
    low_cnt = 0;
    prev_valid = 1'b0;
    bus.dc_req_ready = 1'b0;
    bus.dc_wr_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        wait_cnt = -1;
        low_cnt = 0;
        prev_valid = 1'b0;
        bus.dc_req_ready = 1'b0;
        bus.dc_wr_done = stray_done;
      end else begin
        acc = prev_valid && bus.dc_req_ready;
        bus.dc_wr_done = stray_done;
        if (acc) begin
          wait_cnt = done_delay;
          low_cnt = 0;
        end
        if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            bus.dc_wr_done = 1'b1;
            wait_cnt = -1;
          end
        end
        if (bus.dc_req_valid && !acc) begin
          if (low_cnt >= ready_lat) begin
            bus.dc_req_ready = 1'b1;
            if (done_with_ready) bus.dc_wr_done = 1'b1;
          end else begin
            bus.dc_req_ready = 1'b0;
            low_cnt++;
          end
        end else begin
          bus.dc_req_ready = 1'b0;
        end
        prev_valid = bus.dc_req_valid;
      end
    end
  end

  // Monitor on the falling edge: request order, hold stability, single outstanding request.
  int          n_req = 0;
  int          n_done = 0;
  bit          inflight = 1'b0;
  bit          pv = 1'b0;
  bit          pacc = 1'b0;
  logic [63:0] preq = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight = 1'b0;
      pv = 1'b0;
      pacc = 1'b0;
    end else begin
      if (bus.dc_req_valid) check_eq("one_outstanding", 64'(inflight), 64'(0));
      if (bus.dc_req_valid && pv && !pacc)
        check_eq("req_hold", {bus.dc_req_addr, bus.dc_req_data}, preq);
      if (bus.dc_wr_done && inflight) begin
        inflight = 1'b0;
        n_done++;
      end
      if (bus.dc_req_valid && bus.dc_req_ready) begin
        n_req++;
        check_eq("req_count_le_push", 64'(n_req <= n_push), 64'(1));
        if (exp_q.size() > 0) check_eq("req_order", {bus.dc_req_addr, bus.dc_req_data},
                                        exp_q.pop_front());
        inflight = 1'b1;
      end
      pv = bus.dc_req_valid;
      pacc = bus.dc_req_valid && bus.dc_req_ready;
      preq = {bus.dc_req_addr, bus.dc_req_data};
    end
  end

  task automatic commit(input logic [31:0] a, input logic [31:0] d, input int budget);
    bit ok;
    ok = 1'b0;
    bus.mem_wr_en = 1'b1;
    bus.mem_wr_addr = a;
    bus.mem_wr_data = d;
    for (int i = 0; i < budget && !ok; i++) begin
      ok = !bus.st_stall;
      if (ok) begin
        exp_q.push_back({a, d});
        n_push++;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_wr_en = 1'b0;
    check_eq("commit_accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.sb_empty && exp_q.size() == 0 && !inflight) break;
      @(posedge clk);
      #1;
    end
    check_eq("drain_empty", 64'(bus.sb_empty), 64'(1));
    check_eq("drain_queue", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic probe(input logic valid, input logic [31:0] a, input bit exp_hit,
                       input logic [31:0] exp_data, input bit cmp_data);
    bus.ld_lookup_valid = valid;
    bus.ld_lookup_addr = a;
    #1;
    check_eq("fwd_hit", 64'(bus.ld_fwd_hit), 64'(exp_hit));
    if (cmp_data) check_eq("fwd_data", 64'(bus.ld_fwd_data), 64'(exp_data));
    bus.ld_lookup_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int d0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.ld_lookup_valid = 1'b0;
    bus.ld_lookup_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_stall", 64'(bus.st_stall), 64'(0));
    check_eq("rst_valid", 64'(bus.dc_req_valid), 64'(0));
    check_eq("rst_empty", 64'(bus.sb_empty), 64'(1));
    check_eq("rst_hit", 64'(bus.ld_fwd_hit), 64'(0));
    check_eq("rst_fwd_data", 64'(bus.ld_fwd_data), 64'(0));

    // 1: single store, ready immediately, done three cycles after accept
    ready_lat = 0;
    done_delay = 3;
    commit(32'h100, 32'hAA, 5);
    check_eq("t1_not_empty", 64'(bus.sb_empty), 64'(0));
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #3;
      if (bus.dc_wr_done) break;
    end
    check_eq("t1_done_seen", 64'(bus.dc_wr_done), 64'(1));
    check_eq("t1_empty_in_done_cycle", 64'(bus.sb_empty), 64'(0));
    @(posedge clk);
    #1;
    check_eq("t1_empty_after_done", 64'(bus.sb_empty), 64'(1));
    check_eq("t1_req_count", 64'(n_req), 64'(1));

    // 2: fill with cache not ready, fifth store held until the first completion
    ready_lat = 1000;
    done_delay = 2;
    for (int i = 0; i < 4; i++) commit(32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 5);
    check_eq("t2_stall_full", 64'(bus.st_stall), 64'(1));
    bus.mem_wr_en = 1'b1;
    bus.mem_wr_addr = 32'h310;
    bus.mem_wr_data = 32'h3004;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_stall_hold", 64'(bus.st_stall), 64'(1));
      @(posedge clk);
      #1;
    end
    d0 = n_done;
    ready_lat = 0;
    commit(32'h310, 32'h3004, 60);
    check_eq("t2_fifth_after_done", 64'(n_done > d0), 64'(1));
    wait_drain(200);

    // 3: ready held low five cycles, done pulse alongside ready must not complete
    ready_lat = 5;
    done_delay = 2;
    done_with_ready = 1'b1;
    r0 = n_req;
    commit(32'h400, 32'h11, 5);
    commit(32'h404, 32'h22, 5);
    wait_drain(200);
    done_with_ready = 1'b0;
    check_eq("t3_req_count", 64'(n_req - r0), 64'(2));

    // 4: ten stores through the four-entry buffer with interleaved drain
    done_delay = 1;
    r0 = n_req;
    for (int i = 0; i < 10; i++) begin
      ready_lat = i % 3;
      commit(32'h1000 + 32'(i * 4), $urandom, 60);
    end
    wait_drain(400);
    check_eq("t4_req_count", 64'(n_req - r0), 64'(10));

    // 5: forwarding, youngest match wins, entry in REQ still searchable
    ready_lat = 1000;
    commit(32'h208, 32'h3, 5);
    commit(32'h200, 32'h1, 5);
    commit(32'h200, 32'h2, 5);
    probe(1'b1, 32'h200, FwdEn, FwdEn ? 32'h2 : 32'h0, 1'b1);
    probe(1'b1, 32'h204, 1'b0, 32'h0, 1'b0);
    probe(1'b1, 32'h208, FwdEn, FwdEn ? 32'h3 : 32'h0, 1'b1);
    probe(1'b0, 32'h200, 1'b0, 32'h0, 1'b0);
    ready_lat = 0;
    wait_drain(200);
    probe(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);

    // 6: reset while waiting for completion with three entries held
    done_delay = 1000;
    for (int i = 0; i < 3; i++) commit(32'h500 + 32'(i * 4), 32'h50 + 32'(i), 5);
    for (int i = 0; i < 20; i++) begin
      if (inflight) break;
      @(posedge clk);
      #1;
    end
    check_eq("t6_inflight", 64'(inflight), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    n_push = n_req;
    check_eq("t6_valid", 64'(bus.dc_req_valid), 64'(0));
    check_eq("t6_empty", 64'(bus.sb_empty), 64'(1));
    check_eq("t6_stall", 64'(bus.st_stall), 64'(0));
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    stray_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_late_done_empty", 64'(bus.sb_empty), 64'(1));
    check_eq("t6_late_done_valid", 64'(bus.dc_req_valid), 64'(0));
    probe(1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    done_delay = 1;
    r0 = n_req;
    commit(32'h600, 32'h66, 5);
    wait_drain(100);
    check_eq("t6_post_reset_req", 64'(n_req - r0), 64'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
